tl_ul_buffer: RTL

TL_UL_BUFFER -- requirements
Module: tl_ul_buffer

---
 rtl/tl_ul_pkg.sv | 44 ++++
 rtl/tl_queue.sv | 76 +++++++
 rtl/tl_ul_buffer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL definitions: opcode constants, default-width beat structs
// and the occupancy-counter width helper used by the buffer and its queues.
package tl_ul_pkg;

  localparam logic [2:0] TL_PUT_FULL        = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] TL_GET             = 3'd4;
  localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  localparam int unsigned TL_ADDR_W = 32;
  localparam int unsigned TL_DATA_W = 32;
  localparam int unsigned TL_SIZE_W = 4;
  localparam int unsigned TL_SRC_W  = 4;
  localparam int unsigned TL_MASK_W = TL_DATA_W / 8;

  typedef struct packed {
    logic [2:0]           opcode;
    logic [2:0]           param;
    logic [TL_SIZE_W-1:0] size;
    logic [TL_SRC_W-1:0]  source;
    logic [TL_ADDR_W-1:0] address;
    logic [TL_MASK_W-1:0] mask;
    logic [TL_DATA_W-1:0] data;
    logic                 corrupt;
  } tl_a_beat_t;

  typedef struct packed {
    logic [2:0]           opcode;
    logic [1:0]           param;
    logic [TL_SIZE_W-1:0] size;
    logic [TL_SRC_W-1:0]  source;
    logic                 sink;
    logic                 denied;
    logic [TL_DATA_W-1:0] data;
    logic                 corrupt;
  } tl_d_beat_t;

  // A zero-depth queue still needs a one-bit (constant zero) count port.
  function automatic int unsigned tl_cnt_w(input int unsigned depth);
    return (depth == 0) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/tl_queue.sv
// Generic in-order valid/ready FIFO with optional empty-queue bypass;
// DEPTH=0 degenerates to wires.
module tl_queue
  import tl_ul_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  parameter bit          FLOW  = 1'b0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [tl_cnt_w(DEPTH)-1:0] count
);

  localparam int unsigned CNT_W = tl_cnt_w(DEPTH);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign out_valid      = in_valid;
    assign in_ready       = out_ready;
    assign out_data       = in_data;
    assign count          = '0;
    assign unused_clk_rst = clock ^ reset;
  end else begin : g_fifo
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             empty;
    logic             full;
    logic             bypass;
    logic             push;
    logic             pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty     = (cnt == '0);
    assign full      = (cnt == CNT_W'(DEPTH));
    assign in_ready  = ~reset & ~full;
    assign out_valid = ~reset & (~empty | (FLOW & in_valid));
    assign out_data  = empty ? in_data : mem[rd_ptr];
    // A beat that leaves combinationally through an empty queue is never stored.
    assign bypass    = FLOW & empty & out_ready;
    assign push      = in_valid & in_ready & ~bypass;
    assign pop       = out_ready & ~empty & ~reset;
    assign count     = cnt;

    always_ff @(posedge clock) begin
      if (reset) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) wr_ptr <= inc(wr_ptr);
        if (pop)  rd_ptr <= inc(rd_ptr);
        if (push != pop) cnt <= push ? cnt + CNT_W'(1) : cnt - CNT_W'(1);
      end
    end

    // Payload storage carries no reset; only control state is cleared.
    always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: rtl/tl_ul_buffer.sv
// TileLink-UL channel buffer: independent A (master->slave) and D
// (slave->master) queues carrying the beat fields untouched.
module tl_ul_buffer
  import tl_ul_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SIZE_W  = 4,
  parameter int unsigned SRC_W   = 4,
  parameter int unsigned A_DEPTH = 2,
  parameter int unsigned D_DEPTH = 2,
  parameter bit          A_FLOW  = 1'b0,
  parameter bit          D_FLOW  = 1'b0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_a_valid,
  output logic                         in_a_ready,
  input  logic [2:0]                   in_a_opcode,
  input  logic [2:0]                   in_a_param,
  input  logic [SIZE_W-1:0]            in_a_size,
  input  logic [SRC_W-1:0]             in_a_source,
  input  logic [ADDR_W-1:0]            in_a_address,
  input  logic [DATA_W/8-1:0]          in_a_mask,
  input  logic [DATA_W-1:0]            in_a_data,
  input  logic                         in_a_corrupt,
  output logic                         out_a_valid,
  input  logic                         out_a_ready,
  output logic [2:0]                   out_a_opcode,
  output logic [2:0]                   out_a_param,
  output logic [SIZE_W-1:0]            out_a_size,
  output logic [SRC_W-1:0]             out_a_source,
  output logic [ADDR_W-1:0]            out_a_address,
  output logic [DATA_W/8-1:0]          out_a_mask,
  output logic [DATA_W-1:0]            out_a_data,
  output logic                         out_a_corrupt,
  input  logic                         in_d_valid,
  output logic                         in_d_ready,
  input  logic [2:0]                   in_d_opcode,
  input  logic [1:0]                   in_d_param,
  input  logic [SIZE_W-1:0]            in_d_size,
  input  logic [SRC_W-1:0]             in_d_source,
  input  logic                         in_d_sink,
  input  logic                         in_d_denied,
  input  logic [DATA_W-1:0]            in_d_data,
  input  logic                         in_d_corrupt,
  output logic                         out_d_valid,
  input  logic                         out_d_ready,
  output logic [2:0]                   out_d_opcode,
  output logic [1:0]                   out_d_param,
  output logic [SIZE_W-1:0]            out_d_size,
  output logic [SRC_W-1:0]             out_d_source,
  output logic                         out_d_sink,
  output logic                         out_d_denied,
  output logic [DATA_W-1:0]            out_d_data,
  output logic                         out_d_corrupt,
  output logic [tl_cnt_w(A_DEPTH)-1:0] a_count,
  output logic [tl_cnt_w(D_DEPTH)-1:0] d_count
);

  localparam int unsigned MASK_W = DATA_W / 8;

  // Parameter-width beat layouts; tl_a_beat_t/tl_d_beat_t are the default-width forms.
  typedef struct packed {
    logic [2:0]        opcode;
    logic [2:0]        param;
    logic [SIZE_W-1:0] size;
    logic [SRC_W-1:0]  source;
    logic [ADDR_W-1:0] address;
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] data;
    logic              corrupt;
  } a_beat_t;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [1:0]        param;
    logic [SIZE_W-1:0] size;
    logic [SRC_W-1:0]  source;
    logic              sink;
    logic              denied;
    logic [DATA_W-1:0] data;
    logic              corrupt;
  } d_beat_t;

  a_beat_t a_in;
  a_beat_t a_out;
  d_beat_t d_in;
  d_beat_t d_out;

  assign a_in = '{opcode: in_a_opcode, param: in_a_param, size: in_a_size,
                  source: in_a_source, address: in_a_address, mask: in_a_mask,
                  data: in_a_data, corrupt: in_a_corrupt};

  assign d_in = '{opcode: in_d_opcode, param: in_d_param, size: in_d_size,
                  source: in_d_source, sink: in_d_sink, denied: in_d_denied,
                  data: in_d_data, corrupt: in_d_corrupt};

  tl_queue #(.WIDTH($bits(a_beat_t)), .DEPTH(A_DEPTH), .FLOW(A_FLOW)) u_a_queue (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_a_valid),
    .in_ready (in_a_ready),
    .in_data  (a_in),
    .out_valid(out_a_valid),
    .out_ready(out_a_ready),
    .out_data (a_out),
    .count    (a_count)
  );

  tl_queue #(.WIDTH($bits(d_beat_t)), .DEPTH(D_DEPTH), .FLOW(D_FLOW)) u_d_queue (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_d_valid),
    .in_ready (in_d_ready),
    .in_data  (d_in),
    .out_valid(out_d_valid),
    .out_ready(out_d_ready),
    .out_data (d_out),
    .count    (d_count)
  );

  assign out_a_opcode  = a_out.opcode;
  assign out_a_param   = a_out.param;
  assign out_a_size    = a_out.size;
  assign out_a_source  = a_out.source;
  assign out_a_address = a_out.address;
  assign out_a_mask    = a_out.mask;
  assign out_a_data    = a_out.data;
  assign out_a_corrupt = a_out.corrupt;

  assign out_d_opcode  = d_out.opcode;
  assign out_d_param   = d_out.param;
  assign out_d_size    = d_out.size;
  assign out_d_source  = d_out.source;
  assign out_d_sink    = d_out.sink;
  assign out_d_denied  = d_out.denied;
  assign out_d_data    = d_out.data;
  assign out_d_corrupt = d_out.corrupt;

endmodule
